// File: rtl/multicycle_control_fsm.sv
// Multicycle CPU control unit: decodes opcode/funct into ALU and datapath selects and
// sequences fetch..writeback, waiting on a variable-latency memory with an optional abort.
module multicycle_control_fsm #(
  parameter int unsigned MEM_WAIT_LIMIT = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [2:0] ALU_control,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic       IorD,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       PCEn,
  output logic       mem_error,
  output logic [3:0] state
);

  localparam int unsigned CW = (MEM_WAIT_LIMIT > 255) ? $clog2(MEM_WAIT_LIMIT + 1) : 8;
  localparam logic [CW-1:0] LIMIT_LAST = CW'(MEM_WAIT_LIMIT - 1);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    RTEX   = 4'd6,
    RTWB   = 4'd7,
    BEQ    = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JMP    = 4'd11
  } state_t;

  state_t        cur_state;
  state_t        nxt_state;
  logic [CW-1:0] wait_cnt;
  logic          waiting;
  logic          timeout;
  logic          pc_write;
  logic          branch;

  assign state   = cur_state;
  assign waiting = (cur_state == FETCH) || (cur_state == MEMRD) || (cur_state == MEMWR);
  // mem_ready in the limit cycle still completes the access normally
  assign timeout = (MEM_WAIT_LIMIT != 0) && waiting && !mem_ready && (wait_cnt == LIMIT_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cur_state <= FETCH;
      wait_cnt  <= '0;
      mem_error <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      if (timeout) begin
        mem_error <= 1'b1;
      end
      if (timeout || (nxt_state != cur_state)) begin
        wait_cnt <= '0;
      end else if (waiting && !mem_ready) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    nxt_state   = cur_state;
    ALU_control = ALU_ADD;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSrc       = 2'b00;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    MemWrite    = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    pc_write    = 1'b0;
    branch      = 1'b0;

    case (cur_state)
      FETCH: begin
        ALUSrcB  = 2'b01;
        IRWrite  = mem_ready;
        pc_write = mem_ready;
        if (mem_ready) nxt_state = DECODE;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (opcode)
          OP_LW, OP_SW: nxt_state = MEMADR;
          OP_R:         nxt_state = RTEX;
          OP_BEQ:       nxt_state = BEQ;
          OP_ADDI:      nxt_state = ADDIEX;
          OP_J:         nxt_state = JMP;
          default:      nxt_state = FETCH;
        endcase
      end
      MEMADR: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        nxt_state = (opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        IorD = 1'b1;
        if (mem_ready) nxt_state = MEMWB;
        else if (timeout) nxt_state = FETCH;
      end
      MEMWB: begin
        MemtoReg  = 1'b1;
        RegWrite  = 1'b1;
        nxt_state = FETCH;
      end
      MEMWR: begin
        IorD     = 1'b1;
        MemWrite = !timeout;
        if (mem_ready || timeout) nxt_state = FETCH;
      end
      RTEX: begin
        ALUSrcA = 1'b1;
        case (funct)
          6'b100010: ALU_control = ALU_SUB;
          6'b100100: ALU_control = ALU_AND;
          6'b100101: ALU_control = ALU_OR;
          6'b101010: ALU_control = ALU_SLT;
          default:   ALU_control = ALU_ADD;
        endcase
        nxt_state = RTWB;
      end
      RTWB: begin
        RegDst    = 1'b1;
        RegWrite  = 1'b1;
        nxt_state = FETCH;
      end
      BEQ: begin
        ALUSrcA     = 1'b1;
        ALU_control = ALU_SUB;
        PCSrc       = 2'b01;
        branch      = 1'b1;
        nxt_state   = FETCH;
      end
      ADDIEX: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        nxt_state = ADDIWB;
      end
      ADDIWB: begin
        RegWrite  = 1'b1;
        nxt_state = FETCH;
      end
      JMP: begin
        PCSrc     = 2'b10;
        pc_write  = 1'b1;
        nxt_state = FETCH;
      end
      default: nxt_state = FETCH;
    endcase

    PCEn = pc_write | (branch & zero);

    // Held reset masks every strobe so an abandoned instruction cannot write anything
    if (!reset_n) begin
      nxt_state   = FETCH;
      ALU_control = ALU_ADD;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      PCSrc       = 2'b00;
      IorD        = 1'b0;
      IRWrite     = 1'b0;
      MemWrite    = 1'b0;
      RegDst      = 1'b0;
      MemtoReg    = 1'b0;
      RegWrite    = 1'b0;
      PCEn        = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: per-cycle expected output vectors are queued with the
// stimulus and compared as each cycle is driven.
module tb_multicycle_control_fsm;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3;
  localparam logic [3:0] S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_RTEX = 4'd6, S_RTWB = 4'd7;
  localparam logic [3:0] S_BEQ = 4'd8, S_ADDIEX = 4'd9, S_ADDIWB = 4'd10, S_JMP = 4'd11;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
  localparam logic [5:0] OP_BAD = 6'b111111;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic [2:0] ALU_control;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSrc;
  logic       IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite, PCEn, mem_error;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] st;
    logic [2:0] alu;
    logic       sa;
    logic [1:0] sb;
    logic [1:0] pc;
    logic       iord, irw, mw, rd, mtr, rw, pcen, err;
  } obs_t;

  typedef struct packed {
    logic       rst_n;
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    logic       rdy;
  } stim_t;

  stim_t stim_q[$];
  obs_t  exp_q[$];

  multicycle_control_fsm #(.MEM_WAIT_LIMIT(4)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .ALU_control(ALU_control), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .PCSrc(PCSrc), .IorD(IorD), .IRWrite(IRWrite), .MemWrite(MemWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .PCEn(PCEn), .mem_error(mem_error), .state(state)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(logic [3:0] st, logic [2:0] alu, logic sa, logic [1:0] sb,
                              logic [1:0] pc, logic iord, logic irw, logic mw, logic rd,
                              logic mtr, logic rw, logic pcen, logic err);
    obs_t o;
    o = '{st: st, alu: alu, sa: sa, sb: sb, pc: pc, iord: iord, irw: irw, mw: mw,
          rd: rd, mtr: mtr, rw: rw, pcen: pcen, err: err};
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o = '{st: state, alu: ALU_control, sa: ALUSrcA, sb: ALUSrcB, pc: PCSrc, iord: IorD,
          irw: IRWrite, mw: MemWrite, rd: RegDst, mtr: MemtoReg, rw: RegWrite, pcen: PCEn,
          err: mem_error};
    return o;
  endfunction

  task automatic sched(input logic rst_n, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic rdy, input obs_t e);
    stim_q.push_back('{rst_n: rst_n, op: op, fn: fn, z: z, rdy: rdy});
    exp_q.push_back(e);
  endtask

  task automatic drive(input stim_t s);
    @(negedge clk);
    reset_n   = s.rst_n;
    opcode    = s.op;
    funct     = s.fn;
    zero      = s.z;
    mem_ready = s.rdy;
    #1;
  endtask

  task automatic test_reset();
    obs_t e, got;
    int cyc = 0;
    sched(0, OP_R, 6'b100000, 1, 1, mk(S_FETCH, 3'b010, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
    sched(0, OP_J, 6'b100000, 1, 1, mk(S_FETCH, 3'b010, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
    sched(1, OP_R, 6'b100000, 0, 0, mk(S_FETCH, 3'b010, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      got = sample();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset cyc%0d: got %h expected %h", cyc, got, e);
      end
      cyc++;
    end
  endtask

  task automatic test_rtype();
    logic [5:0] fn_tab [6];
    logic [2:0] alu_tab [6];
    obs_t e, got;
    int cyc = 0;
    fn_tab  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};
    alu_tab = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b010};
    for (int i = 0; i < 6; i++) begin
      sched(1, OP_R, fn_tab[i], 0, 1, mk(S_FETCH, 3'b010, 0, 2'b01, 2'b00, 0, 1, 0, 0, 0, 0, 1, 0));
      sched(1, OP_R, fn_tab[i], 0, 1, mk(S_DECODE, 3'b010, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
      sched(1, OP_R, fn_tab[i], 0, 1, mk(S_RTEX, alu_tab[i], 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
      sched(1, OP_R, fn_tab[i], 0, 1, mk(S_RTWB, 3'b010, 0, 2'b00, 2'b00, 0, 0, 0, 1, 0, 1, 0, 0));
    end
    while (exp_q.size() > 0) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      got = sample();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL rtype cyc%0d: got %h expected %h", cyc, got, e);
      end
      cyc++;
    end
  endtask

  task automatic test_beq();
    obs_t e, got;
    int cyc = 0;
    for (int z = 1; z >= 0; z--) begin
      sched(1, OP_BEQ, 0, 1'(z), 1, mk(S_FETCH, 3'b010, 0, 2'b01, 2'b00, 0, 1, 0, 0, 0, 0, 1, 0));
      sched(1, OP_BEQ, 0, 1'(z), 1, mk(S_DECODE, 3'b010, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
      sched(1, OP_BEQ, 0, 1'(z), 1, mk(S_BEQ, 3'b110, 1, 2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 1'(z), 0));
    end
    while (exp_q.size() > 0) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      got = sample();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL beq cyc%0d: got %h expected %h", cyc, got, e);
      end
      cyc++;
    end
  endtask

  task automatic test_lw_wait();
    obs_t e, got;
    int cyc = 0;
    sched(1, OP_LW, 0, 0, 1, mk(S_FETCH, 3'b010, 0, 2'b01, 2'b00, 0, 1, 0, 0, 0, 0, 1, 0));
    sched(1, OP_LW, 0, 0, 1, mk(S_DECODE, 3'b010, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
    sched(1, OP_LW, 0, 0, 1, mk(S_MEMADR, 3'b010, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
    // three stalls, then ready lands exactly in the abort-limit cycle and must win
    for (int i = 0; i < 4; i++)
      sched(1, OP_LW, 0, 0, 1'(i == 3), mk(S_MEMRD, 3'b010, 0, 2'b00, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0));
    sched(1, OP_LW, 0, 0, 0, mk(S_MEMWB, 3'b010, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 1, 0, 0));
    while (exp_q.size() > 0) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      got = sample();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL lw cyc%0d: got %h expected %h", cyc, got, e);
      end
      cyc++;
    end
  endtask

  task automatic test_sw_wait();
    obs_t e, got;
    int cyc = 0;
    sched(1, OP_SW, 0, 0, 1, mk(S_FETCH, 3'b010, 0, 2'b01, 2'b00, 0, 1, 0, 0, 0, 0, 1, 0));
    sched(1, OP_SW, 0, 0, 1, mk(S_DECODE, 3'b010, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
    sched(1, OP_SW, 0, 0, 1, mk(S_MEMADR, 3'b010, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      sched(1, OP_SW, 0, 0, 1'(i == 2), mk(S_MEMWR, 3'b010, 0, 2'b00, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0));
    sched(1, OP_SW, 0, 0, 0, mk(S_FETCH, 3'b010, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      got = sample();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL sw cyc%0d: got %h expected %h", cyc, got, e);
      end
      cyc++;
    end
  endtask

  task automatic test_addi_jmp_nop();
    obs_t e, got;
    int cyc = 0;
    sched(1, OP_ADDI, 0, 0, 1, mk(S_FETCH, 3'b010, 0, 2'b01, 2'b00, 0, 1, 0, 0, 0, 0, 1, 0));
    sched(1, OP_ADDI, 0, 0, 1, mk(S_DECODE, 3'b010, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
    sched(1, OP_ADDI, 0, 0, 1, mk(S_ADDIEX, 3'b010, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
    sched(1, OP_ADDI, 0, 0, 1, mk(S_ADDIWB, 3'b010, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0));
    sched(1, OP_J, 0, 0, 1, mk(S_FETCH, 3'b010, 0, 2'b01, 2'b00, 0, 1, 0, 0, 0, 0, 1, 0));
    sched(1, OP_J, 0, 0, 1, mk(S_DECODE, 3'b010, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
    sched(1, OP_J, 0, 0, 1, mk(S_JMP, 3'b010, 0, 2'b00, 2'b10, 0, 0, 0, 0, 0, 0, 1, 0));
    sched(1, OP_BAD, 0, 0, 1, mk(S_FETCH, 3'b010, 0, 2'b01, 2'b00, 0, 1, 0, 0, 0, 0, 1, 0));
    sched(1, OP_BAD, 0, 0, 1, mk(S_DECODE, 3'b010, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      got = sample();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL addi_jmp_nop cyc%0d: got %h expected %h", cyc, got, e);
      end
      cyc++;
    end
  endtask

  task automatic test_mem_timeout();
    obs_t e, got;
    int cyc = 0;
    for (int i = 0; i < 4; i++)
      sched(1, OP_BAD, 0, 0, 0, mk(S_FETCH, 3'b010, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
    sched(1, OP_BAD, 0, 0, 0, mk(S_FETCH, 3'b010, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1));
    sched(1, OP_BAD, 0, 0, 1, mk(S_FETCH, 3'b010, 0, 2'b01, 2'b00, 0, 1, 0, 0, 0, 0, 1, 1));
    sched(1, OP_BAD, 0, 0, 1, mk(S_DECODE, 3'b010, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1));
    while (exp_q.size() > 0) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      got = sample();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL mem_timeout cyc%0d: got %h expected %h", cyc, got, e);
      end
      cyc++;
    end
  endtask

  task automatic test_reset_mid_store();
    obs_t e, got;
    int cyc = 0;
    sched(1, OP_SW, 0, 0, 1, mk(S_FETCH, 3'b010, 0, 2'b01, 2'b00, 0, 1, 0, 0, 0, 0, 1, 1));
    sched(1, OP_SW, 0, 0, 1, mk(S_DECODE, 3'b010, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1));
    sched(1, OP_SW, 0, 0, 1, mk(S_MEMADR, 3'b010, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1));
    sched(1, OP_SW, 0, 0, 0, mk(S_MEMWR, 3'b010, 0, 2'b00, 2'b00, 1, 0, 1, 0, 0, 0, 0, 1));
    sched(0, OP_SW, 0, 0, 1, mk(S_MEMWR, 3'b010, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1));
    sched(0, OP_SW, 0, 0, 1, mk(S_FETCH, 3'b010, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
    sched(1, OP_BAD, 0, 0, 1, mk(S_FETCH, 3'b010, 0, 2'b01, 2'b00, 0, 1, 0, 0, 0, 0, 1, 0));
    sched(1, OP_BAD, 0, 0, 1, mk(S_DECODE, 3'b010, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
    sched(1, OP_BAD, 0, 0, 0, mk(S_FETCH, 3'b010, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      got = sample();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset_mid_store cyc%0d: got %h expected %h", cyc, got, e);
      end
      cyc++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_rtype();
    test_beq();
    test_lw_wait();
    test_sw_wait();
    test_addi_jmp_nop();
    test_mem_timeout();
    test_reset_mid_store();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
